// File: rtl/dac_spi_scheduler_if.sv
// Sample/acknowledge handshake and DAC serial pins of dac_spi_scheduler.
// The master side is the sample generator, the slave side is the scheduler.
interface dac_spi_scheduler_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        ack_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        ack_b;
    logic        sck;
    logic        sdi;
    logic        cs_n;
    logic        busy;
    logic        done;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  ack_a, ack_b, sck, sdi, cs_n, busy, done
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output ack_a, ack_b, sck, sdi, cs_n, busy, done
    );
endinterface

// File: rtl/dac_spi_scheduler.sv
// Two-channel round-robin arbiter and 24-bit SPI master for the dual 16-bit DAC.
// Define DAC_OFFSET_BINARY_EN to convert two's complement samples to offset binary.
module dac_spi_scheduler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dac_spi_scheduler_if.slave   io_dac
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_HI = 3'd2,
        ST_SCK_LO = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    function automatic logic [15:0] data_field(input logic [15:0] sample);
`ifdef DAC_OFFSET_BINARY_EN
        data_field = {~sample[15], sample[14:0]};
`else
        data_field = sample;
`endif
    endfunction

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [4:0]  r_bits;
    logic [23:0] r_shift;
    logic        r_sck;
    logic        r_sdi;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_done;
    logic        r_prefer_b;

    state_t      w_state;
    logic [7:0]  w_cnt;
    logic [4:0]  w_bits;
    logic [23:0] w_shift;
    logic        w_sck;
    logic        w_sdi;
    logic        w_cs_n;
    logic        w_busy;
    logic        w_done;
    logic        w_prefer_b;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_div_end;
    logic        w_gap_end;

    // Only B beats A when both ask and A was served last; reset gates every grant.
    assign w_grant_a = (r_state == ST_IDLE) && !i_rst && io_dac.req_a
                       && (!io_dac.req_b || !r_prefer_b);
    assign w_grant_b = (r_state == ST_IDLE) && !i_rst && io_dac.req_b
                       && (!io_dac.req_a || r_prefer_b);
    assign w_div_end = (r_cnt == DIV_LAST);
    assign w_gap_end = (r_cnt == GAP_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bits     = r_bits;
        w_shift    = r_shift;
        w_sck      = r_sck;
        w_sdi      = r_sdi;
        w_cs_n     = r_cs_n;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_prefer_b = r_prefer_b;
        case (r_state)
            ST_IDLE: begin
                w_cnt = 8'd0;
                if (w_grant_a || w_grant_b) begin
                    w_shift    = w_grant_b ? {8'h01, data_field(io_dac.data_b)}
                                           : {8'h00, data_field(io_dac.data_a)};
                    w_sdi      = w_shift[23];
                    w_cs_n     = 1'b0;
                    w_busy     = 1'b1;
                    w_bits     = 5'd0;
                    w_prefer_b = w_grant_a;
                    w_state    = ST_SETUP;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_div_end) begin
                    w_cnt   = 8'd0;
                    w_sck   = 1'b1;
                    w_state = ST_SCK_HI;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_SCK_HI: begin
                if (w_div_end) begin
                    w_cnt   = 8'd0;
                    w_sck   = 1'b0;
                    w_bits  = r_bits + 5'd1;
                    w_shift = {r_shift[22:0], 1'b0};
                    w_sdi   = r_shift[22];
                    w_state = ST_SCK_LO;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_SCK_LO: begin
                // The trailing low half-period after the last bit precedes the CS_ hold time.
                if (w_div_end) begin
                    w_cnt = 8'd0;
                    if (r_bits == 5'd24) begin
                        w_state = ST_HOLD;
                    end else begin
                        w_sck   = 1'b1;
                        w_state = ST_SCK_HI;
                    end
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_div_end) begin
                    w_cnt   = 8'd0;
                    w_cs_n  = 1'b1;
                    w_sdi   = 1'b0;
                    w_done  = 1'b1;
                    w_state = ST_GAP;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_cnt   = 8'd0;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_cnt   = 8'd0;
                w_sck   = 1'b0;
                w_sdi   = 1'b0;
                w_cs_n  = 1'b1;
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_bits     <= 5'd0;
            r_shift    <= 24'd0;
            r_sck      <= 1'b0;
            r_sdi      <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_prefer_b <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bits     <= w_bits;
            r_shift    <= w_shift;
            r_sck      <= w_sck;
            r_sdi      <= w_sdi;
            r_cs_n     <= w_cs_n;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_prefer_b <= w_prefer_b;
        end
    end

    assign io_dac.ack_a = w_grant_a;
    assign io_dac.ack_b = w_grant_b;
    assign io_dac.sck   = r_sck;
    assign io_dac.sdi   = r_sdi;
    assign io_dac.cs_n  = r_cs_n;
    assign io_dac.busy  = r_busy;
    assign io_dac.done  = r_done;
endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Scoreboard bench: a cycle-count reference model predicts grants and pin levels,
// a pin monitor decodes each SPI frame and compares it with the queued expectation.
`timescale 1ns/1ps
module tb_dac_spi_scheduler;
    localparam int D0 = 4;
    localparam int G0 = 8;
    localparam int LOW0 = 50 * D0;
    localparam logic [15:0] DATA1 = 16'hA5C3;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_spi_scheduler_if bus0();
    dac_spi_scheduler_if bus1();

    dac_spi_scheduler #(.CLK_DIV(D0), .GAP_CYCLES(G0)) dut0 (
        .i_clk(clk), .i_rst(rst), .io_dac(bus0)
    );
    dac_spi_scheduler #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .io_dac(bus1)
    );

    function automatic logic [23:0] exp_frame(input bit ch_b, input logic [15:0] d);
        logic [15:0] f;
`ifdef DAC_OFFSET_BINARY_EN
        f = d + 16'h8000;
`else
        f = d;
`endif
        return {7'd0, ch_b, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    endtask

    // Reference model: after a grant the block is busy for 50*D+G cycles.
    int wait_cnt = 0;
    bit prefer_b = 1'b0;
    logic [23:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            check("ack_in_reset", {30'd0, bus0.ack_a, bus0.ack_b}, 32'd0);
            wait_cnt = 0;
            prefer_b = 1'b0;
            exp_q.delete();
        end else begin
            bit ga, gb;
            check("busy", bus0.busy, wait_cnt > 0);
            check("cs_n", bus0.cs_n, !(wait_cnt > G0));
            check("done", bus0.done, wait_cnt == G0);
            ga = 1'b0;
            gb = 1'b0;
            if (wait_cnt == 0) begin
                if (bus0.req_a && bus0.req_b) begin
                    ga = !prefer_b;
                    gb = prefer_b;
                end else begin
                    ga = bus0.req_a;
                    gb = bus0.req_b;
                end
            end else begin
                wait_cnt--;
            end
            check("ack_a", bus0.ack_a, ga);
            check("ack_b", bus0.ack_b, gb);
            if (ga || gb) begin
                exp_q.push_back(exp_frame(gb, gb ? bus0.data_b : bus0.data_a));
                prefer_b = ga;
                wait_cnt = LOW0 + G0;
            end
        end
    end

    // Pin monitor for dut0: decode frames and compare against the scoreboard.
    logic p_sck0 = 1'b0;
    logic p_cs0  = 1'b1;
    bit   in_frame = 1'b0;
    int   rises0 = 0;
    int   low_len = 0;
    logic [23:0] sh0 = 24'd0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (p_cs0 && !bus0.cs_n) begin
                check("sck_at_cs_fall", bus0.sck, 1'b0);
                in_frame = 1'b1;
                rises0 = 0;
                low_len = 0;
                sh0 = 24'd0;
            end
            if (!bus0.cs_n) begin
                low_len++;
                if (!p_sck0 && bus0.sck) begin
                    rises0++;
                    sh0 = {sh0[22:0], bus0.sdi};
                end
            end
            if (!p_cs0 && bus0.cs_n) begin
                check("sck_at_cs_rise", bus0.sck, 1'b0);
                if (in_frame) begin
                    check("rises", rises0, 24);
                    check("cs_low_len", low_len, LOW0);
                    if (exp_q.size() == 0) timeout("frame_unexpected");
                    else check("frame", sh0, exp_q.pop_front());
                    in_frame = 1'b0;
                end
            end
        end
        p_sck0 = bus0.sck;
        p_cs0  = bus0.cs_n;
    end

    // Pin monitor for dut1 (CLK_DIV=1, GAP_CYCLES=1) under continuous REQ_A.
    logic p_sck1 = 1'b0;
    logic p_cs1  = 1'b1;
    bit   f1 = 1'b0;
    bit   seen1 = 1'b0;
    int   rises1 = 0;
    int   hi1 = 0;
    logic [23:0] sh1 = 24'd0;

    always @(negedge clk) begin
        if (!rst1) begin
            if (p_cs1 && !bus1.cs_n) begin
                if (seen1) check("gap1_cs_high", hi1, 2);
                f1 = 1'b1;
                rises1 = 0;
                sh1 = 24'd0;
            end
            if (!bus1.cs_n) begin
                if (!p_sck1 && bus1.sck) begin
                    rises1++;
                    sh1 = {sh1[22:0], bus1.sdi};
                end
            end else begin
                hi1++;
            end
            if (!p_cs1 && bus1.cs_n && f1) begin
                check("rises1", rises1, 24);
                check("frame1", sh1, exp_frame(1'b0, DATA1));
                seen1 = 1'b1;
                hi1 = 1;
                f1 = 1'b0;
            end
        end
        p_sck1 = bus1.sck;
        p_cs1  = bus1.cs_n;
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input bit ua, input bit ub, input logic [15:0] da, input logic [15:0] db);
        bit pa, pb;
        int budget;
        pa = ua;
        pb = ub;
        budget = 3000;
        drive_edge();
        bus0.data_a = da;
        bus0.data_b = db;
        bus0.req_a  = ua;
        bus0.req_b  = ub;
        while ((pa || pb) && budget > 0) begin
            @(negedge clk);
            if (bus0.ack_a) pa = 1'b0;
            if (bus0.ack_b) pb = 1'b0;
            drive_edge();
            if (!pa) bus0.req_a = 1'b0;
            if (!pb) bus0.req_b = 1'b0;
            budget--;
        end
        if (pa || pb) begin
            timeout("send_ack");
            bus0.req_a = 1'b0;
            bus0.req_b = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        drive_edge();
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;
    endtask

    initial begin
        int n, budget;
        logic [2:0] mask;
        bus0.req_a = 1'b0; bus0.req_b = 1'b0; bus0.data_a = 16'd0; bus0.data_b = 16'd0;
        bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.data_a = DATA1; bus1.data_b = 16'd0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        rst1 = 1'b0;
        bus1.req_a = 1'b1;

        // Idle after reset: serial pins quiet.
        repeat (100) begin
            @(negedge clk);
            check("idle_sck", bus0.sck, 1'b0);
            check("idle_sdi", bus0.sdi, 1'b0);
        end

        send(1'b1, 1'b0, 16'h1234, 16'h0000);
        send(1'b0, 1'b1, 16'h0000, 16'h8000);
        repeat (300) @(posedge clk);

        // Both channels held from reset: grants alternate A, B, A, B.
        pulse_reset();
        bus0.data_a = 16'h7FFF;
        bus0.data_b = 16'h0001;
        bus0.req_a = 1'b1;
        bus0.req_b = 1'b1;
        n = 0;
        budget = 3000;
        while (n < 4 && budget > 0) begin
            @(negedge clk);
            if (bus0.ack_a || bus0.ack_b) n++;
            budget--;
        end
        if (n < 4) timeout("alternate_grants");
        drive_edge();
        bus0.req_a = 1'b0;
        bus0.req_b = 1'b0;
        repeat (300) @(posedge clk);

        // Reset at the 10th SCK rise; held REQ_B is granted a fresh frame.
        drive_edge();
        bus0.data_b = 16'h5A3C;
        bus0.req_b = 1'b1;
        n = 0;
        budget = 1000;
        while (n < 10 && budget > 0) begin
            @(negedge clk);
            if (!p_sck0 && bus0.sck && !bus0.cs_n) n++;
            budget--;
        end
        if (n < 10) timeout("tenth_rise");
        pulse_reset();
        @(negedge clk);
        check("rst_sck", bus0.sck, 1'b0);
        drive_edge();
        budget = 1000;
        while (budget > 0 && !(wait_cnt > 0)) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout("regrant_b");
        bus0.req_b = 1'b0;
        repeat (300) @(posedge clk);

        // Random traffic, with requests that come and go while a frame runs.
        for (int i = 0; i < 25; i++) begin
            mask = 3'($urandom_range(1, 3));
            send(mask[0], mask[1], 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                drive_edge();
                bus0.data_b = 16'($urandom);
                bus0.req_b = 1'b1;
                repeat (3) @(posedge clk);
                #2;
                bus0.req_b = 1'b0;
            end
            repeat ($urandom_range(0, 300)) @(posedge clk);
        end

        bus1.req_a = 1'b0;
        repeat (400) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("dut1_frames_seen", {31'd0, seen1}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
